cva6_dcache_flush_ctrl: RTL
===========================

// Module: cva6_dcache_flush_ctrl
// PURPOSE
// - Fence/flush sequencer sitting directly upstream of the write-back HPDcache request port.
// - Accepts FENCE / FENCE.I / SFENCE.VMA from the commit controller and drains in-flight stores.
// - Issues one flush (optionally flush+invalidate) to the dcache, waits for completion, then signals done.
// - Stalls new load/store issue for the duration of the sequence.
// PARAMETERS
// - FlushOnFence       1'b1  plain FENCE also triggers a dcache flush (FENCE.I always flushes)
// - InvalidateOnFlush  1'b0  drive flush_req_inval_o=1 so lines are invalidated after write-back
// - MaxOutstandingStores 7   upper bound of outstanding_st_i; OstW = $clog2(MaxOutstandingStores+1)
// - CycW               32    width of flush_cycles_o duration counter
// PORTS
// - clk_i              in   1     core clock
// - rst_i              in   1     reset, asynchronous, active-high
// - fence_valid_i      in   1     fence request from commit controller
// - fence_ready_o      out  1     request accepted (valid&ready same cycle)
// - fence_kind_i       in   2     fence_kind_t: 0 FENCE, 1 FENCE_I, 2 SFENCE_VMA, 3 reserved (treated as FENCE)
// - kill_i             in   1     pipeline flush/exception; aborts only while draining
// - stb_empty_i        in   1     store buffer holds no committed/speculative entries
// - outstanding_st_i   in   OstW  stores issued to dcache not yet acknowledged
// - flush_req_valid_o  out  1     flush request to HPDcache
// - flush_req_ready_i  in   1     HPDcache accepts flush request
// - flush_req_inval_o  out  1     flush also invalidates (= InvalidateOnFlush), valid with req
// - flush_rsp_valid_i  in   1     HPDcache flush complete (single-cycle pulse)
// - done_o             out  1     one-cycle pulse: fence sequence complete
// - busy_o             out  1     any state other than IDLE
// - ld_st_stall_o      out  1     block new LSU issue; = busy_o
// - flush_cycles_o     out  CycW  cycles from acceptance to done_o of last completed sequence
// BEHAVIOUR
// - Reset (async, rst_i=1): state=IDLE; all outputs 0 except fence_ready_o=1; counters 0.
// - FSM: IDLE -> DRAIN -> {FLUSH -> WAIT_RSP ->} DONE -> IDLE.
// - IDLE: fence_ready_o=1 iff !kill_i. Accept on fence_valid_i&fence_ready_o; latch need_flush =
//   (kind==FENCE_I) | (FlushOnFence & kind!=SFENCE_VMA). Start duration count at 1.
// - DRAIN: wait stb_empty_i & outstanding_st_i==0 (both sampled same cycle); then go FLUSH if
//   need_flush else DONE. kill_i in DRAIN -> IDLE, no done_o, flush_cycles_o unchanged.
// - FLUSH: flush_req_valid_o=1, held stable until flush_req_ready_i; on handshake -> WAIT_RSP.
//   kill_i ignored from FLUSH onward (flush must complete).
// - WAIT_RSP: wait flush_rsp_valid_i -> DONE. A rsp pulse arriving in any other state is dropped.
// - DONE: done_o=1 for exactly one cycle; flush_cycles_o <= counter; -> IDLE. fence_ready_o=0 here
//   (earliest back-to-back accept is the cycle after done_o).
// - Latency minimum (no flush, drained at accept): accept cycle N, DRAIN N+1, done_o at N+2.
// - Latency minimum (flush, ready & rsp immediate): done_o at N+4.
// - Duration counter saturates at all-ones; never wraps.
// - fence_valid_i while busy: not accepted, no side effect. fence_valid_i & kill_i in IDLE: not accepted.
// - outstanding_st_i > MaxOutstandingStores: simulation assertion error; treated as nonzero.
// - Assertions: flush_req_valid_o stable until ready; done_o never two consecutive cycles.
// STRUCTURE
// - Shared package cva6_flush_pkg: fence_kind_t enum (2b), flush_state_e enum
//   (IDLE, DRAIN, FLUSH, WAIT_RSP, DONE).
// - One sub-module: cva6_sat_counter #(W) (clear, enable, saturating increment) for the duration count.
// - FSM + need_flush flag + output decode in this module; all outputs registered or state-decoded, no
//   combinational path from flush_rsp_valid_i to done_o.
// TESTING
// - FENCE_I, stb_empty_i=1, outstanding=0, ready/rsp immediate -> one req handshake, done_o at N+4,
//   flush_cycles_o=4.
// - FENCE with FlushOnFence=0, outstanding_st_i=3 dropping to 0 after 5 cycles -> no flush_req_valid_o,
//   done_o 1 cycle after drain, ld_st_stall_o high throughout.
// - FENCE_I with flush_req_ready_i low 10 cycles -> valid held stable 10 cycles, single handshake,
//   rsp 6 cycles later -> done_o next cycle.
// - kill_i in DRAIN -> IDLE, no done_o, no req; kill_i during WAIT_RSP -> ignored, done_o still pulses.
// - Second fence_valid_i held high through sequence -> accepted only the cycle after done_o;
//   SFENCE_VMA -> drain only.
// - rst_i asserted in WAIT_RSP -> outputs reset immediately; later stray rsp pulse in IDLE -> no done_o.

Source files
------------

// File: rtl/cva6_flush_pkg.sv
// ============================================================================
// Module : cva6_flush_pkg
// Brief  : Shared fence kinds, flush sequencer states and flush decision helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cva6_flush_pkg;

  typedef enum logic [1:0] {
    FENCE      = 2'd0,
    FENCE_I    = 2'd1,
    SFENCE_VMA = 2'd2,
    FENCE_RSVD = 2'd3
  } fence_kind_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    FLUSH    = 3'd2,
    WAIT_RSP = 3'd3,
    DONE     = 3'd4
  } flush_state_e;

  // Reserved encoding behaves like a plain FENCE.
  function automatic logic needs_flush(input fence_kind_t kind, input logic flush_on_fence);
    return (kind == FENCE_I) | (flush_on_fence & (kind != SFENCE_VMA));
  endfunction

endpackage

`default_nettype wire

// File: rtl/cva6_sat_counter.sv
// ============================================================================
// Module : cva6_sat_counter
// Brief  : Saturating up-counter; clear and enable together load one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cva6_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] base;

  always_comb begin
    base  = clear_i ? '0 : cnt_q;
    cnt_d = base;
    if (en_i && !(&base)) begin
      cnt_d = base + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cva6_dcache_flush_ctrl.sv
// ============================================================================
// Module : cva6_dcache_flush_ctrl
// Brief  : Fence sequencer: drain stores, optionally flush the dcache, pulse done.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cva6_dcache_flush_ctrl
  import cva6_flush_pkg::*;
#(
  parameter bit          FlushOnFence         = 1'b1,
  parameter bit          InvalidateOnFlush    = 1'b0,
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned CycW                 = 32,
  localparam int unsigned OstW                = $clog2(MaxOutstandingStores + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fence_valid_i,
  output logic            fence_ready_o,
  input  logic [1:0]      fence_kind_i,
  input  logic            kill_i,
  input  logic            stb_empty_i,
  input  logic [OstW-1:0] outstanding_st_i,
  output logic            flush_req_valid_o,
  input  logic            flush_req_ready_i,
  output logic            flush_req_inval_o,
  input  logic            flush_rsp_valid_i,
  output logic            done_o,
  output logic            busy_o,
  output logic            ld_st_stall_o,
  output logic [CycW-1:0] flush_cycles_o
);

  flush_state_e    state_q, state_d;
  logic            need_flush_q, need_flush_d;
  logic [CycW-1:0] flush_cycles_q;
  logic [CycW-1:0] dur_cnt;
  logic            accept;
  logic            drained;
  fence_kind_t     kind;

  assign kind    = fence_kind_t'(fence_kind_i);
  assign accept  = (state_q == IDLE) && fence_valid_i && !kill_i;
  assign drained = stb_empty_i && (outstanding_st_i == '0);

  always_comb begin
    state_d      = state_q;
    need_flush_d = need_flush_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = DRAIN;
          need_flush_d = needs_flush(kind, FlushOnFence);
        end
      end
      DRAIN: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (drained) begin
          state_d = need_flush_q ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        if (flush_req_ready_i) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (flush_rsp_valid_i) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      need_flush_q   <= 1'b0;
      flush_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      need_flush_q <= need_flush_d;
      if (state_q == DONE) begin
        flush_cycles_q <= dur_cnt;
      end
    end
  end

  // Accept cycle counts as cycle one; the count then runs while busy.
  cva6_sat_counter #(
    .W (CycW)
  ) u_dur_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (accept),
    .en_i    (accept || (state_q != IDLE)),
    .cnt_o   (dur_cnt)
  );

  assign fence_ready_o     = (state_q == IDLE) && !kill_i;
  assign flush_req_valid_o = (state_q == FLUSH);
  assign flush_req_inval_o = (state_q == FLUSH) && InvalidateOnFlush;
  assign done_o            = (state_q == DONE);
  assign busy_o            = (state_q != IDLE);
  assign ld_st_stall_o     = busy_o;
  assign flush_cycles_o    = flush_cycles_q;

`ifndef SYNTHESIS
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (flush_req_valid_o && !flush_req_ready_i) |=> flush_req_valid_o);
  a_done_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    done_o |=> !done_o);
  a_ost_range: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(outstanding_st_i) <= 32'(MaxOutstandingStores));
`endif

endmodule

`default_nettype wire
